// File: rtl/regfile_sb_pkg.sv
// rf_pkg: shared constants and types for the regfile_sb register file.
//   XLEN      default data width
//   NREGS/AW  default register count and matching index width
//   REG_ZERO  hard-wired zero register index
//   REG_T0    register loaded by the trigger port
//   REG_A0    register mirrored on the a0 debug output
package rf_pkg;
  localparam int XLEN     = 32;
  localparam int NREGS    = 32;
  localparam int AW       = $clog2(NREGS);
  localparam int PEND_MAX = 3;
  localparam int REG_ZERO = 0;
  localparam int REG_T0   = 5;
  localparam int REG_A0   = 10;

  typedef logic [AW-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: bundle of read, writeback, issue, trigger and debug signals.
//   master : pipeline side (drives addresses, writeback, issue, trigger)
//   slave  : register file side (returns read data, busy, iss_ready, trig_lost, a0)
interface regfile_sb_if import rf_pkg::*; #(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = AW,
  parameter int N_RD   = 2
) ();
  logic [N_RD-1:0][ADDR_W-1:0] rd_addr;
  logic [N_RD-1:0][DATA_W-1:0] rd_data;
  logic [N_RD-1:0]             rd_busy;
  logic                        wr_en;
  logic [ADDR_W-1:0]           wr_addr;
  logic [DATA_W-1:0]           wr_data;
  logic                        iss_en;
  logic [ADDR_W-1:0]           iss_rd;
  logic                        iss_ready;
  logic                        trig_we;
  logic [DATA_W-1:0]           trig_data;
  logic                        trig_lost;
  logic [DATA_W-1:0]           a0;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd, trig_we, trig_data,
    input  rd_data, rd_busy, iss_ready, trig_lost, a0
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd, trig_we, trig_data,
    output rd_data, rd_busy, iss_ready, trig_lost, a0
  );
endinterface

// File: rtl/regfile_sb_scoreboard.sv
// rf_scoreboard: per-register pending-write counters for hazard detection.
//   clk, rst_n         clock, async active-low reset
//   iss_en, iss_rd     issue request and its destination register
//   iss_ready          issue accepted (destination counter not saturated)
//   wr_en, wr_addr     writeback retiring one pending write
//   rd_addr, rd_busy   per read port: source still waiting on a producer
module rf_scoreboard
  import rf_pkg::REG_ZERO;
#(
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int PEND_MAX = 3,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      iss_en,
  input  logic [AW-1:0]             iss_rd,
  output logic                      iss_ready,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [NREAD-1:0][AW-1:0]  rd_addr,
  output logic [NREAD-1:0]          rd_busy
);
  localparam int CW = $clog2(PEND_MAX + 1);
  localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);
  localparam logic [CW-1:0] CNT_MAX  = CW'(PEND_MAX);

  logic [CW-1:0] cnt [NREGS];
  logic          iss_fire;

  // Readiness looks only at the stored count; a same-cycle writeback does not free a slot.
  assign iss_ready = (iss_rd == ZERO_IDX) || (cnt[iss_rd] < CNT_MAX);
  assign iss_fire  = iss_en && iss_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        // Simultaneous issue and writeback cancel; writeback at zero saturates at zero.
        if (iss_fire && iss_rd == AW'(r) && !(wr_en && wr_addr == AW'(r)))
          cnt[r] <= cnt[r] + 1'b1;
        else if (wr_en && wr_addr == AW'(r) && !(iss_fire && iss_rd == AW'(r))
                 && cnt[r] != '0)
          cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  // A writeback arriving this cycle covers one pending write, so only a count above
  // that is a real stall; the final producer is forwarded by the bypass path.
  always_comb begin
    for (int i = 0; i < NREAD; i++) begin
      rd_busy[i] = 1'b0;
      if (rd_addr[i] != ZERO_IDX) begin
        if (wr_en && wr_addr == rd_addr[i])
          rd_busy[i] = cnt[rd_addr[i]] > CW'(1);
        else
          rd_busy[i] = cnt[rd_addr[i]] != '0;
      end
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: RV32I integer register file with write->read bypass, pending-write
// scoreboard, trigger load port and registered debug mirror.
//   clk, rst_n   clock, async active-low reset
//   bus (slave)  read ports, writeback, issue handshake, trigger, trig_lost, a0
module regfile_sb
  import rf_pkg::REG_ZERO, rf_pkg::REG_T0, rf_pkg::REG_A0;
#(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int PEND_MAX = 3,
  parameter int TRIG_REG = REG_T0,
  parameter int DBG_REG  = REG_A0
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);
  localparam logic [AW-1:0] TRIG_IDX = AW'(TRIG_REG);

  logic [XLEN-1:0]            regs [NREGS];
  logic [NREAD-1:0][XLEN-1:0] rd_data_c;
  logic [XLEN-1:0]            a0_q;
  logic                       trig_lost_q;
  logic                       wb_we;
  logic                       trig_hit;
  logic                       trig_win;

  assign wb_we    = bus.wr_en && bus.wr_addr != ZERO_IDX;
  assign trig_hit = bus.wr_en && bus.wr_addr == TRIG_IDX;
  // Writeback always has priority over the trigger when both target the same register.
  assign trig_win = bus.trig_we && !trig_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      a0_q        <= '0;
      trig_lost_q <= 1'b0;
    end else begin
      if (wb_we)    regs[bus.wr_addr] <= bus.wr_data;
      if (trig_win) regs[TRIG_REG]    <= bus.trig_data;
      trig_lost_q <= bus.trig_we && trig_hit;
      a0_q        <= regs[DBG_REG];
    end
  end

  always_comb begin
    for (int i = 0; i < NREAD; i++) begin
      rd_data_c[i] = regs[bus.rd_addr[i]];
      if (bus.rd_addr[i] == ZERO_IDX)
        rd_data_c[i] = '0;
      else if (bus.wr_en && bus.wr_addr == bus.rd_addr[i])
        rd_data_c[i] = bus.wr_data;
      else if (trig_win && bus.rd_addr[i] == TRIG_IDX)
        rd_data_c[i] = bus.trig_data;
    end
  end

  assign bus.rd_data   = rd_data_c;
  assign bus.a0        = a0_q;
  assign bus.trig_lost = trig_lost_q;

  rf_scoreboard #(
    .NREGS    (NREGS),
    .NREAD    (NREAD),
    .PEND_MAX (PEND_MAX),
    .AW       (AW)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_en    (bus.iss_en),
    .iss_rd    (bus.iss_rd),
    .iss_ready (bus.iss_ready),
    .wr_en     (bus.wr_en),
    .wr_addr   (bus.wr_addr),
    .rd_addr   (bus.rd_addr),
    .rd_busy   (bus.rd_busy)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed stimulus; expected responses are queued per cycle and a
// negedge monitor pops and compares them against the DUT outputs.
module tb_regfile_sb;
  localparam int K_DATA  = 0;
  localparam int K_BUSY  = 1;
  localparam int K_READY = 2;
  localparam int K_LOST  = 3;
  localparam int K_A0    = 4;

  typedef struct {
    string       name;
    int          kind;
    int          port;
    logic [31:0] exp;
    int          cyc;
  } chk_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  chk_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .N_RD(2)) bus ();

  regfile_sb #(
    .XLEN(32), .NREGS(32), .NREAD(2), .PEND_MAX(3), .TRIG_REG(5), .DBG_REG(10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rd_addr   = '0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.iss_en    = 1'b0;
    bus.iss_rd    = '0;
    bus.trig_we   = 1'b0;
    bus.trig_data = '0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
  endtask

  task automatic iss(input logic [4:0] a);
    bus.iss_en = 1'b1;
    bus.iss_rd = a;
  endtask

  task automatic expect_v(input string name, input int kind, input int port,
                          input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.kind = kind;
    c.port = port;
    c.exp  = exp;
    c.cyc  = cyc;
    q.push_back(c);
  endtask

  function automatic logic [31:0] actual(input int kind, input int port);
    case (kind)
      K_DATA:  return bus.rd_data[port];
      K_BUSY:  return {31'd0, bus.rd_busy[port]};
      K_READY: return {31'd0, bus.iss_ready};
      K_LOST:  return {31'd0, bus.trig_lost};
      default: return bus.a0;
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      chk_t c;
      logic [31:0] got;
      c = q.pop_front();
      n_checks++;
      if (c.cyc < cyc) begin
        n_errors++;
        $display("FAIL %s: not sampled in cycle %0d (now %0d)", c.name, c.cyc, cyc);
      end else begin
        got = actual(c.kind, c.port);
        if (got !== c.exp) begin
          n_errors++;
          $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                   c.name, got, c.exp, cyc);
        end
      end
    end
  end

  initial begin
    int guard;
    idle();
    rst_n = 1'b0;
    repeat (3) step();

    // T1 reset and x0
    rst_n = 1'b1;
    expect_v("rst_data0", K_DATA, 0, 32'h0);
    expect_v("rst_data1", K_DATA, 1, 32'h0);
    expect_v("rst_ready", K_READY, 0, 32'h1);
    expect_v("rst_lost",  K_LOST, 0, 32'h0);
    expect_v("rst_a0",    K_A0, 0, 32'h0);
    step(); idle(); wb(5'd0, 32'hDEADBEEF);
    expect_v("x0_nobypass", K_DATA, 0, 32'h0);
    step(); idle(); bus.rd_addr[1] = 5'd1;
    expect_v("x0_after", K_DATA, 0, 32'h0);
    expect_v("x1_zero",  K_DATA, 1, 32'h0);

    // T2 bypass
    step(); idle(); wb(5'd7, 32'h1234); bus.rd_addr[0] = 5'd7;
    expect_v("bypass_x7", K_DATA, 0, 32'h1234);
    step(); bus.wr_en = 1'b0; bus.rd_addr[1] = 5'd7;
    expect_v("stored_x7_p0", K_DATA, 0, 32'h1234);
    expect_v("stored_x7_p1", K_DATA, 1, 32'h1234);

    // T3 scoreboard
    step(); idle(); iss(5'd3);
    expect_v("iss3_a", K_READY, 0, 32'h1);
    step();
    expect_v("iss3_b", K_READY, 0, 32'h1);
    step(); idle(); bus.rd_addr[0] = 5'd3;
    expect_v("busy3_cnt2", K_BUSY, 0, 32'h1);
    step(); wb(5'd3, 32'h33);
    expect_v("busy3_wb1", K_BUSY, 0, 32'h1);
    expect_v("fwd3_wb1",  K_DATA, 0, 32'h33);
    step(); bus.wr_en = 1'b0;
    expect_v("busy3_cnt1", K_BUSY, 0, 32'h1);
    step(); wb(5'd3, 32'h3333);
    expect_v("busy3_final", K_BUSY, 0, 32'h0);
    expect_v("fwd3_final",  K_DATA, 0, 32'h3333);
    step(); bus.wr_en = 1'b0;
    expect_v("busy3_done", K_BUSY, 0, 32'h0);
    expect_v("data3_done", K_DATA, 0, 32'h3333);

    // T4 saturation
    step(); idle(); iss(5'd4);
    expect_v("iss4_1", K_READY, 0, 32'h1);
    step();
    expect_v("iss4_2", K_READY, 0, 32'h1);
    step();
    expect_v("iss4_3", K_READY, 0, 32'h1);
    step(); bus.rd_addr[1] = 5'd4;
    expect_v("iss4_sat",   K_READY, 0, 32'h0);
    expect_v("busy4_sat",  K_BUSY, 1, 32'h1);
    step();
    expect_v("iss4_sat2",  K_READY, 0, 32'h0);
    step(); bus.iss_en = 1'b0; wb(5'd4, 32'h40);
    expect_v("busy4_wb_cnt3", K_BUSY, 1, 32'h1);
    step(); iss(5'd4); wb(5'd4, 32'h44);
    expect_v("iss4_with_wb", K_READY, 0, 32'h1);
    expect_v("fwd4",         K_DATA, 1, 32'h44);
    step(); bus.wr_en = 1'b0;
    expect_v("iss4_cnt2", K_READY, 0, 32'h1);
    step();
    expect_v("iss4_cnt3", K_READY, 0, 32'h0);
    step(); idle(); bus.rd_addr[1] = 5'd4; iss(5'd7);
    expect_v("iss7_ready", K_READY, 0, 32'h1);
    step(); bus.iss_en = 1'b0; bus.rd_addr[0] = 5'd7;
    expect_v("busy7_one", K_BUSY, 0, 32'h1);
    expect_v("busy4_held", K_BUSY, 1, 32'h1);

    // T5 trigger conflict
    step(); idle(); bus.trig_we = 1'b1; bus.trig_data = 32'hAA;
    wb(5'd5, 32'h55); bus.rd_addr[0] = 5'd5;
    expect_v("conflict_fwd",  K_DATA, 0, 32'h55);
    expect_v("conflict_lost0", K_LOST, 0, 32'h0);
    step(); idle(); bus.rd_addr[0] = 5'd5;
    expect_v("conflict_x5",   K_DATA, 0, 32'h55);
    expect_v("conflict_lost1", K_LOST, 0, 32'h1);
    step(); bus.trig_we = 1'b1; bus.trig_data = 32'hAA;
    expect_v("trig_bypass",   K_DATA, 0, 32'hAA);
    expect_v("lost_cleared",  K_LOST, 0, 32'h0);
    step(); idle(); bus.rd_addr[0] = 5'd5;
    expect_v("trig_stored",   K_DATA, 0, 32'hAA);
    expect_v("lost_stays0",   K_LOST, 0, 32'h0);

    // T6 a0 and async reset
    step(); idle(); wb(5'd10, 32'h99);
    expect_v("a0_before", K_A0, 0, 32'h0);
    step(); idle();
    expect_v("a0_lag", K_A0, 0, 32'h0);
    step();
    expect_v("a0_updated", K_A0, 0, 32'h99);
    step(); idle(); bus.rd_addr[0] = 5'd7; bus.rd_addr[1] = 5'd4; bus.iss_rd = 5'd4;
    #1 rst_n = 1'b0;
    expect_v("arst_a0",    K_A0, 0, 32'h0);
    expect_v("arst_busy7", K_BUSY, 0, 32'h0);
    expect_v("arst_busy4", K_BUSY, 1, 32'h0);
    expect_v("arst_ready4", K_READY, 0, 32'h1);
    expect_v("arst_x7",    K_DATA, 0, 32'h0);
    step(); rst_n = 1'b1; bus.rd_addr[0] = 5'd10;
    expect_v("post_rst_x10",  K_DATA, 0, 32'h0);
    expect_v("post_rst_busy4", K_BUSY, 1, 32'h0);
    step(); idle();

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left unsampled, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
